// File: rtl/hl2_cw_pkg.sv
// Shared encodings for the CW keyer: mode values, FSM states and element timer sizing.
package hl2_cw_pkg;
    localparam logic [1:0] MODE_STRAIGHT     = 2'b00;
    localparam logic [1:0] MODE_IAMBIC_A     = 2'b01;
    localparam logic [1:0] MODE_IAMBIC_B     = 2'b10;
    localparam logic [1:0] MODE_STRAIGHT_ALT = 2'b11;

    localparam int DASH_RATIO = 3;
    localparam int TIMER_W    = 13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DOT  = 2'd1,
        ST_DASH = 2'd2,
        ST_GAP  = 2'd3
    } keyer_state_t;

    function automatic logic is_iambic(input logic [1:0] mode);
        return !((mode == MODE_STRAIGHT) || (mode == MODE_STRAIGHT_ALT));
    endfunction
endpackage

// File: rtl/cw_debounce.sv
// One paddle contact: 2-FF synchroniser, plus a tick-based stability filter when
// CW_KEYER_DEBOUNCE_EN is defined. Output stays active low, released = 1.
module cw_debounce
    import hl2_cw_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic raw_n,
    output logic level_n
);
    logic [1:0] sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync <= 2'b11;
        else     sync <= {sync[0], raw_n};
    end

`ifdef CW_KEYER_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);
    logic [CNT_W-1:0] cnt;

    // Any return to the current level before the count completes restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            level_n <= 1'b1;
        end else if (sync[1] == level_n) begin
            cnt <= '0;
        end else if (tick) begin
            if (cnt >= CNT_W'(DEBOUNCE_TICKS - 1)) begin
                level_n <= sync[1];
                cnt     <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = tick & (DEBOUNCE_TICKS > 0);
    assign level_n    = sync[1];
`endif
endmodule

// File: rtl/cw_iambic_keyer.sv
// Straight / iambic A / iambic B CW keyer; debounce filter enabled by CW_KEYER_DEBOUNCE_EN.
// state   | meaning
// IDLE    | no element timed (straight mode lives here)
// DOT     | keydown, timing N ticks
// DASH    | keydown, timing 3N ticks
// GAP     | key up, timing N ticks after an element
module cw_iambic_keyer
    import hl2_cw_pkg::*;
#(
    parameter int TICK_DIV       = 7680,
    parameter int DEBOUNCE_TICKS = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_dot_n,
    input  logic        key_dash_n,
    input  logic        cfg_enable,
    input  logic [1:0]  cfg_mode,
    input  logic        cfg_reverse,
    input  logic [10:0] cfg_dot_ticks,
    output logic        keydown,
    output logic        keyer_busy
);
    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

    keyer_state_t       state, state_nxt;
    logic [PRESC_W-1:0] presc;
    logic               tick, presc_clr;
    logic [TIMER_W-1:0] timer, load_val, n_cur, n_q;
    logic               load_en, expire, start_dot, start_dash;
    logic               dot_mem, dash_mem, dot_mem_nxt, dash_mem_nxt;
    logic               last_dash;
    logic [1:0]         mode_q;
    logic               dot_raw_n, dash_raw_n, dot_db, dash_db;
    logic               straight_active, keydown_nxt;

    cw_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_dot (
        .clk(clk), .rst(rst), .tick(tick), .raw_n(key_dot_n), .level_n(dot_raw_n)
    );
    cw_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_dash (
        .clk(clk), .rst(rst), .tick(tick), .raw_n(key_dash_n), .level_n(dash_raw_n)
    );

    assign dot_db  = cfg_reverse ? ~dash_raw_n : ~dot_raw_n;
    assign dash_db = cfg_reverse ? ~dot_raw_n  : ~dash_raw_n;

    assign tick            = (presc == PRESC_LAST);
    assign n_cur           = (cfg_dot_ticks == 11'd0) ? TIMER_W'(1) : TIMER_W'(cfg_dot_ticks);
    assign expire          = tick && (timer <= TIMER_W'(1));
    assign straight_active = (state == ST_IDLE) && !is_iambic(cfg_mode);
    assign keyer_busy      = straight_active ? keydown : (state != ST_IDLE);

    always_comb begin
        state_nxt    = state;
        load_en      = 1'b0;
        load_val     = n_q;
        start_dot    = 1'b0;
        start_dash   = 1'b0;
        dot_mem_nxt  = dot_mem;
        dash_mem_nxt = dash_mem;
        presc_clr    = 1'b0;

        case (state)
            ST_IDLE: begin
                dot_mem_nxt  = 1'b0;
                dash_mem_nxt = 1'b0;
                if (is_iambic(cfg_mode)) begin
                    start_dot  = dot_db;
                    start_dash = !dot_db && dash_db;
                end
            end
            ST_DOT, ST_DASH: begin
                if (expire) begin
                    state_nxt = ST_GAP;
                    load_en   = 1'b1;
                    load_val  = n_q;
                end
            end
            ST_GAP: begin
                if (expire) begin
                    if (!is_iambic(cfg_mode))       state_nxt  = ST_IDLE;
                    else if (!last_dash) begin
                        if (dash_db || dash_mem)    start_dash = 1'b1;
                        else if (dot_db)            start_dot  = 1'b1;
                        else                        state_nxt  = ST_IDLE;
                    end else begin
                        if (dot_db || dot_mem)      start_dot  = 1'b1;
                        else if (dash_db)           start_dash = 1'b1;
                        else                        state_nxt  = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Squeeze memory: set before the start logic so a starting element clears its own flag.
        if (mode_q == MODE_IAMBIC_B) begin
            if ((state == ST_DOT || (state == ST_GAP && !last_dash)) && dash_db) dash_mem_nxt = 1'b1;
            if ((state == ST_DASH || (state == ST_GAP && last_dash)) && dot_db)  dot_mem_nxt  = 1'b1;
        end

        if (!cfg_enable) begin
            start_dot    = 1'b0;
            start_dash   = 1'b0;
            state_nxt    = ST_IDLE;
            load_en      = 1'b0;
            dot_mem_nxt  = 1'b0;
            dash_mem_nxt = 1'b0;
        end

        if (start_dot) begin
            state_nxt   = ST_DOT;
            load_en     = 1'b1;
            load_val    = n_cur;
            dot_mem_nxt = 1'b0;
        end else if (start_dash) begin
            state_nxt    = ST_DASH;
            load_en      = 1'b1;
            load_val     = TIMER_W'(DASH_RATIO) * n_cur;
            dash_mem_nxt = 1'b0;
        end

        presc_clr   = (state == ST_IDLE) && (start_dot || start_dash);
        keydown_nxt = cfg_enable &&
                      (straight_active ? dot_db : (state_nxt == ST_DOT || state_nxt == ST_DASH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            presc     <= '0;
            timer     <= '0;
            n_q       <= TIMER_W'(1);
            mode_q    <= MODE_STRAIGHT;
            last_dash <= 1'b0;
            dot_mem   <= 1'b0;
            dash_mem  <= 1'b0;
            keydown   <= 1'b0;
        end else begin
            state    <= state_nxt;
            dot_mem  <= dot_mem_nxt;
            dash_mem <= dash_mem_nxt;
            keydown  <= keydown_nxt;
            presc    <= (presc_clr || tick) ? '0 : presc + PRESC_W'(1);
            if (load_en)                    timer <= load_val;
            else if (tick && timer != '0)   timer <= timer - TIMER_W'(1);
            if (start_dot || start_dash) begin
                n_q       <= n_cur;
                mode_q    <= cfg_mode;
                last_dash <= start_dash;
            end
        end
    end
endmodule

// File: tb/tb_cw_iambic_keyer.sv
// Scoreboard bench for cw_iambic_keyer: expected keydown pulses are queued by the
// stimulus and popped by a monitor each time a keydown pulse completes.
module tb_cw_iambic_keyer;
    localparam int TICK_DIV       = 10;
    localparam int DEBOUNCE_TICKS = 2;
`ifdef CW_KEYER_DEBOUNCE_EN
    localparam int LAT = -1;
`else
    localparam int LAT = 3;   // 2-FF sync + registered keydown
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_dot_n = 1'b1;
    logic        key_dash_n = 1'b1;
    logic        cfg_enable = 1'b1;
    logic [1:0]  cfg_mode = 2'b10;
    logic        cfg_reverse = 1'b0;
    logic [10:0] cfg_dot_ticks = 11'd5;
    logic        keydown, keyer_busy;

    cw_iambic_keyer #(.TICK_DIV(TICK_DIV), .DEBOUNCE_TICKS(DEBOUNCE_TICKS)) dut (
        .clk(clk), .rst(rst), .key_dot_n(key_dot_n), .key_dash_n(key_dash_n),
        .cfg_enable(cfg_enable), .cfg_mode(cfg_mode), .cfg_reverse(cfg_reverse),
        .cfg_dot_ticks(cfg_dot_ticks), .keydown(keydown), .keyer_busy(keyer_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int lat;   // cycles from stimulus mark to rise, -1 = don't care
        int gap;   // low cycles since previous fall, -1 = don't care
        int len;   // high cycles
    } pulse_t;

    pulse_t exp_q[$];
    pulse_t mon_e;
    int     n_tests = 0, n_fail = 0;
    int     cyc = 0, stim_cyc = 0, rise_cyc = 0, rise_lat = 0, fall_cyc = 0;
    logic   prev_kd = 1'b0;
    string  cur_test = "reset";

    task automatic check(input string name, input int act, input int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_pulse(input int lat, input int gap, input int len);
        pulse_t p;
        p.lat = lat;
        p.gap = gap;
        p.len = len;
        exp_q.push_back(p);
    endtask

    task automatic mark();
        stim_cyc = cyc;
    endtask

    task automatic wait_rise();
        for (int i = 0; i < 400 && keydown !== 1'b1; i++) @(negedge clk);
        check({cur_test, "_rise_seen"}, int'(keydown === 1'b1), 1);
    endtask

    task automatic finish_test();
        check({cur_test, "_pending"}, exp_q.size(), 0);
        check({cur_test, "_idle_busy"}, int'(keyer_busy), 0);
        check({cur_test, "_idle_keydown"}, int'(keydown), 0);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (keydown === 1'b1 && !prev_kd) begin
            rise_cyc = cyc;
            rise_lat = cyc - stim_cyc;
        end
        if (keydown !== 1'b1 && prev_kd) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s_unexpected_pulse: got %0d-clk pulse at cycle %0d, expected none",
                         cur_test, cyc - rise_cyc, rise_cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check({cur_test, "_len"}, cyc - rise_cyc, mon_e.len);
                if (mon_e.lat >= 0) check({cur_test, "_latency"}, rise_lat, mon_e.lat);
                if (mon_e.gap >= 0) check({cur_test, "_gap"}, rise_cyc - fall_cyc, mon_e.gap);
            end
            fall_cyc = cyc;
        end
        prev_kd = (keydown === 1'b1);
    end

    initial begin
        step(3);
        check("reset_keydown", int'(keydown), 0);
        check("reset_busy", int'(keyer_busy), 0);
        rst = 1'b0;
        step(5);
        check("post_reset_keydown", int'(keydown), 0);

        // Iambic B, dot held 300 clk: three dots, nothing after the gap of release
        cur_test = "b_dot_hold";
        cfg_mode = 2'b10;
        expect_pulse(LAT, -1, 50);
        expect_pulse(-1, 50, 50);
        expect_pulse(-1, 50, 50);
        mark(); key_dot_n = 1'b0;
        step(80);
        check("b_dot_hold_gap_keydown", int'(keydown), 0);
        check("b_dot_hold_gap_busy", int'(keyer_busy), 1);
        step(220); key_dot_n = 1'b1;
        step(60);
        finish_test();

        // Iambic B, dash tapped during a dot: dash memory plays a dash
        cur_test = "b_dash_mem";
        expect_pulse(LAT, -1, 50);
        expect_pulse(-1, 50, 150);
        mark(); key_dot_n = 1'b0;
        step(10); key_dash_n = 1'b0;
        step(20); key_dash_n = 1'b1;
        step(10); key_dot_n = 1'b1;
        step(200);
        check("b_dash_mem_mid_dash_keydown", int'(keydown), 1);
        step(100);
        finish_test();

        // Iambic A, same stimulus: no memory, single dot
        cur_test = "a_no_mem";
        cfg_mode = 2'b01;
        expect_pulse(LAT, -1, 50);
        mark(); key_dot_n = 1'b0;
        step(10); key_dash_n = 1'b0;
        step(20); key_dash_n = 1'b1;
        step(10); key_dot_n = 1'b1;
        step(300);
        finish_test();

        // cfg_dot_ticks = 0 acts as 1: 10-clk dot
        cur_test = "a_min_len";
        cfg_dot_ticks = 11'd0;
        expect_pulse(LAT, -1, 10);
        mark(); key_dot_n = 1'b0;
        step(5); key_dot_n = 1'b1;
        step(50);
        cfg_dot_ticks = 11'd5;
        finish_test();

        // Dot length changed mid-element: applies from the next element
        cur_test = "a_len_change";
        expect_pulse(LAT, -1, 50);
        expect_pulse(-1, 50, 20);
        mark(); key_dot_n = 1'b0;
        step(20); cfg_dot_ticks = 11'd2;
        step(90); key_dot_n = 1'b1;
        step(100);
        cfg_dot_ticks = 11'd5;
        finish_test();

        // Reversed paddles: ring contact gives a dot
        cur_test = "b_reverse";
        cfg_mode = 2'b10;
        cfg_reverse = 1'b1;
        expect_pulse(LAT, -1, 50);
        mark(); key_dash_n = 1'b0;
        step(80); key_dash_n = 1'b1;
        step(100);
        cfg_reverse = 1'b0;
        finish_test();

        // Straight mode: keydown follows the dot contact, dash ignored
        cur_test = "straight";
        cfg_mode = 2'b00;
        expect_pulse(LAT, -1, 1000);
        mark(); key_dot_n = 1'b0;
        step(500);
        check("straight_keydown", int'(keydown), 1);
        check("straight_busy", int'(keyer_busy), 1);
        step(500); key_dot_n = 1'b1;
        step(20); key_dash_n = 1'b0;
        step(100);
        check("straight_dash_ignored", int'(keydown), 0);
        key_dash_n = 1'b1;
        step(10);
        finish_test();

        // 3-clk glitch in straight mode
        cur_test = "straight_glitch";
`ifndef CW_KEYER_DEBOUNCE_EN
        expect_pulse(3, -1, 3);
`endif
        mark(); key_dot_n = 1'b0;
        step(3); key_dot_n = 1'b1;
        step(40);
        finish_test();

        // Enable dropped 40 clk into a dash
        cur_test = "b_disable";
        cfg_mode = 2'b10;
        expect_pulse(LAT, -1, 41);
        mark(); key_dash_n = 1'b0;
        wait_rise();
        step(40); cfg_enable = 1'b0;
        @(negedge clk);
        check("b_disable_keydown_before", int'(keydown), 1);
        @(posedge clk); #1;
        check("b_disable_keydown_after", int'(keydown), 0);
        check("b_disable_busy_after", int'(keyer_busy), 0);
        key_dash_n = 1'b1;
        step(10); cfg_enable = 1'b1;
        step(20);
        finish_test();

        // Reset asserted mid-dot clears outputs immediately
        cur_test = "rst_mid_dot";
        expect_pulse(LAT, -1, 17);
        mark(); key_dot_n = 1'b0;
        wait_rise();
        step(17); rst = 1'b1;
        #1;
        check("rst_mid_dot_keydown", int'(keydown), 0);
        check("rst_mid_dot_busy", int'(keyer_busy), 0);
        key_dot_n = 1'b1;
        step(3); rst = 1'b0;
        step(20);
        finish_test();

        step(10);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
